// File: rtl/pwm_capture_module_if.sv
// Bundle of the PWM capture signals: the input waveform plus the measurement results.
// The slave modport is the capture block; the master modport is the source/consumer side.
// Parameterised on the counter width so it tracks the capture block's CNT_W.
interface pwm_capture_module_if #(
    parameter int CNT_W = 24
);
    logic             PWM_In;
    logic [CNT_W-1:0] Period_Cnt;
    logic [CNT_W-1:0] High_Cnt;
    logic [7:0]       Duty;
    logic             Valid;
    logic             Timeout;

    modport slave (
        input  PWM_In,
        output Period_Cnt,
        output High_Cnt,
        output Duty,
        output Valid,
        output Timeout
    );

    modport master (
        output PWM_In,
        input  Period_Cnt,
        input  High_Cnt,
        input  Duty,
        input  Valid,
        input  Timeout
    );
endinterface

// File: rtl/pwm_capture_module.sv
// Measures period, high time and integer duty percent of an asynchronous PWM input.
// Latency: Valid pulses CNT_W+8 cycles after the rise that closes a period.
// No backpressure: Valid is a single-cycle pulse and the outputs hold until the next one.
module pwm_capture_module #(
    parameter int CNT_W     = 24,
    parameter int MAX_COUNT = 1_000_000
) (
    input logic                  CLK,
    input logic                  RST,
    pwm_capture_module_if.slave  bus
);
    localparam int DW = CNT_W + 7;
    localparam int IW = $clog2(DW + 1);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_COUNT);
    localparam logic [DW-1:0]    HUNDRED = DW'(100);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, DIVIDE} state_t;

    logic             s1, s2, s3;
    logic             rise, fall;
    logic [CNT_W-1:0] cnt;

    state_t           state;
    logic [CNT_W-1:0] p_snap, h_snap, h_snap_next;
    logic             have_next, extra_rise;
    logic             seen_edge, to_done;
    logic [CNT_W-1:0] rem;
    logic [DW-1:0]    quo;
    logic [IW-1:0]    iter;

    logic [CNT_W-1:0] period_r, high_r;
    logic [7:0]       duty_r;
    logic             valid_r, timeout_r;

    logic [CNT_W:0]   trial;
    logic             take;
    logic [CNT_W-1:0] rem_nx;
    logic [DW-1:0]    quo_nx;
    logic [7:0]       duty_nx;
    logic             to_fire;

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // A stall fires once when the counter saturates; to_done blocks re-firing until the next rise.
    assign to_fire = (cnt == MAX_C) && !to_done && !rise;

    // Input synchronizer, edge-delay flop and the free-running rise-to-rise cycle counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            s3  <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= bus.PWM_In;
            s2 <= s1;
            s3 <= s2;
            if (rise) begin
                cnt <= CNT_W'(1);
            end else if (cnt != MAX_C) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // One restoring-division step: shift in the next dividend bit, subtract the period if it fits.
    always_comb begin
        trial   = {rem, quo[DW-1]};
        take    = (trial >= {1'b0, p_snap});
        rem_nx  = take ? CNT_W'(trial - {1'b0, p_snap}) : trial[CNT_W-1:0];
        quo_nx  = {quo[DW-2:0], take};
        duty_nx = (quo_nx > HUNDRED) ? 8'd100 : quo_nx[7:0];
    end

    // Capture FSM: snapshots high/period counts, runs the divider and publishes registered results.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            p_snap      <= '0;
            h_snap      <= '0;
            h_snap_next <= '0;
            have_next   <= 1'b0;
            extra_rise  <= 1'b0;
            seen_edge   <= 1'b0;
            to_done     <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            iter        <= '0;
            period_r    <= '0;
            high_r      <= '0;
            duty_r      <= '0;
            valid_r     <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (rise) begin
                to_done <= 1'b0;
            end
            if (rise || fall) begin
                seen_edge <= 1'b1;
            end

            case (state)
                IDLE: begin
                    // First rise only arms; a stall counts once the input has moved at least once.
                    if (rise) begin
                        state <= HIGH;
                    end else if (seen_edge && to_fire) begin
                        timeout_r <= 1'b1;
                        period_r  <= '0;
                        high_r    <= '0;
                        duty_r    <= s2 ? 8'd100 : 8'd0;
                        valid_r   <= 1'b1;
                        to_done   <= 1'b1;
                        state     <= IDLE;
                    end
                end
                HIGH: begin
                    if (to_fire) begin
                        timeout_r <= 1'b1;
                        period_r  <= '0;
                        high_r    <= '0;
                        duty_r    <= s2 ? 8'd100 : 8'd0;
                        valid_r   <= 1'b1;
                        to_done   <= 1'b1;
                        state     <= IDLE;
                    end else if (fall) begin
                        h_snap <= cnt;
                        state  <= LOW;
                    end
                end
                LOW: begin
                    if (to_fire) begin
                        timeout_r <= 1'b1;
                        period_r  <= '0;
                        high_r    <= '0;
                        duty_r    <= s2 ? 8'd100 : 8'd0;
                        valid_r   <= 1'b1;
                        to_done   <= 1'b1;
                        state     <= IDLE;
                    end else if (rise) begin
                        p_snap     <= cnt;
                        quo        <= DW'(h_snap) * HUNDRED;
                        rem        <= '0;
                        iter       <= '0;
                        have_next  <= 1'b0;
                        extra_rise <= 1'b0;
                        state      <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    rem  <= rem_nx;
                    quo  <= quo_nx;
                    iter <= iter + IW'(1);
                    // The counter keeps running, so a fall here is the next period's high time.
                    if (fall) begin
                        h_snap_next <= cnt;
                        have_next   <= 1'b1;
                    end
                    if (rise) begin
                        extra_rise <= 1'b1;
                    end
                    if (iter == IW'(DW - 1)) begin
                        period_r  <= p_snap;
                        high_r    <= h_snap;
                        duty_r    <= duty_nx;
                        valid_r   <= 1'b1;
                        timeout_r <= 1'b0;
                        // The rise that closed this period already opened the next one.
                        if (extra_rise || rise) begin
                            state <= IDLE;
                        end else if (have_next) begin
                            h_snap <= h_snap_next;
                            state  <= LOW;
                        end else if (fall) begin
                            h_snap <= cnt;
                            state  <= LOW;
                        end else begin
                            state <= HIGH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Period_Cnt = period_r;
    assign bus.High_Cnt   = high_r;
    assign bus.Duty       = duty_r;
    assign bus.Valid      = valid_r;
    assign bus.Timeout    = timeout_r;

endmodule

// File: tb/tb_pwm_capture_module.sv
// Directed bench for pwm_capture_module: drives PWM waveforms and checks every Valid report.
// Reports are collected at the falling clock edge and compared against hand-computed values.
// Timeout threshold is lowered so stuck-input cases finish quickly.
module tb_pwm_capture_module;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   last_rise = 0;
    int   r1 = 0;

    typedef struct {
        int c;
        int p;
        int h;
        int d;
        int t;
    } ev_t;
    ev_t evq[$];
    ev_t mon_e;

    always #5 clk = ~clk;

    pwm_capture_module_if #(.CNT_W(24)) bus();

    pwm_capture_module #(.CNT_W(24), .MAX_COUNT(5000)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record every Valid pulse with its cycle stamp.
    always @(negedge clk) begin
        if (bus.Valid === 1'b1) begin
            mon_e.c = cyc;
            mon_e.p = int'(bus.Period_Cnt);
            mon_e.h = int'(bus.High_Cnt);
            mon_e.d = int'(bus.Duty);
            mon_e.t = int'(bus.Timeout);
            evq.push_back(mon_e);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pwm_cycle(input int p, input int h);
        bus.PWM_In = 1'b1;
        last_rise = cyc;
        tick(h);
        bus.PWM_In = 1'b0;
        tick(p - h);
    endtask

    task automatic pwm_run(input int n, input int p, input int h);
        for (int i = 0; i < n; i++) pwm_cycle(p, h);
    endtask

    task automatic expect_ev(input string tag, input int p, input int h, input int d, input int t);
        ev_t e;
        chk({tag, ".avail"}, (evq.size() > 0), 1);
        if (evq.size() > 0) begin
            e = evq.pop_front();
            chk({tag, ".period"}, e.p, p);
            chk({tag, ".high"}, e.h, h);
            chk({tag, ".duty"}, e.d, d);
            chk({tag, ".timeout"}, e.t, t);
        end
    endtask

    task automatic expect_none(input string tag);
        chk({tag, ".extra"}, evq.size(), 0);
        evq.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".period"}, bus.Period_Cnt, 0);
        chk({tag, ".high"}, bus.High_Cnt, 0);
        chk({tag, ".duty"}, bus.Duty, 0);
        chk({tag, ".valid"}, bus.Valid, 0);
        chk({tag, ".timeout"}, bus.Timeout, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        bus.PWM_In = 1'b0;
        rst = 1'b1;
        tick(3);
        check_zero("reset");
        rst = 1'b0;
        tick(5);

        // 1000/300: first rise arms, reports start at the second rise.
        pwm_cycle(1000, 300);
        pwm_cycle(1000, 300);
        r1 = last_rise;
        pwm_run(2, 1000, 300);
        if (evq.size() > 0) chk("first.latency", evq[0].c - r1, 34);
        for (int i = 0; i < 3; i++) expect_ev("p1000", 1000, 300, 30, 0);
        expect_none("p1000");

        // 50% then 10% segments, each switched on a period boundary.
        pwm_run(3, 4000, 2000);
        expect_ev("p1000.tail", 1000, 300, 30, 0);
        for (int i = 0; i < 2; i++) expect_ev("p4000", 4000, 2000, 50, 0);
        expect_none("p4000");
        pwm_run(3, 1000, 100);
        expect_ev("p4000.tail", 4000, 2000, 50, 0);
        for (int i = 0; i < 2; i++) expect_ev("p1000d10", 1000, 100, 10, 0);
        expect_none("p1000d10");

        // 100200/3007 = 33.32 truncates to 33.
        pwm_run(2, 3007, 1002);
        expect_ev("p1000d10.tail", 1000, 100, 10, 0);
        expect_ev("trunc", 3007, 1002, 33, 0);
        expect_none("trunc");

        // Stuck high: one timeout report, no repeats.
        bus.PWM_In = 1'b1;
        tick(6000);
        expect_ev("trunc.tail", 3007, 1002, 33, 0);
        expect_ev("stuck_hi", 0, 0, 100, 1);
        chk("stuck_hi.level", bus.Timeout, 1);
        tick(2000);
        expect_none("stuck_hi");

        // Resume: Timeout holds until the second rise completes a measurement.
        bus.PWM_In = 1'b0;
        tick(700);
        chk("resume.to_held", bus.Timeout, 1);
        pwm_cycle(1000, 300);
        pwm_cycle(1000, 300);
        r1 = last_rise;
        pwm_cycle(1000, 300);
        if (evq.size() > 0) chk("resume.latency", evq[0].c - r1, 34);
        for (int i = 0; i < 2; i++) expect_ev("resume", 1000, 300, 30, 0);
        expect_none("resume");

        // Stuck low after one more full measurement.
        pwm_cycle(1000, 300);
        tick(5500);
        expect_ev("resume.tail", 1000, 300, 30, 0);
        expect_ev("stuck_lo", 0, 0, 0, 1);
        expect_none("stuck_lo");

        // Reset in the middle of a divide.
        pwm_run(2, 1000, 300);
        expect_ev("pre_rst", 1000, 300, 30, 0);
        chk("pre_rst.period_out", bus.Period_Cnt, 1000);
        bus.PWM_In = 1'b1;
        tick(12);
        rst = 1'b1;
        #1;
        check_zero("mid_div_rst");
        bus.PWM_In = 1'b0;
        tick(5);
        rst = 1'b0;
        tick(500);
        expect_none("mid_div_rst");

        // After reset the first report needs two rises.
        pwm_cycle(1000, 300);
        pwm_cycle(1000, 300);
        r1 = last_rise;
        pwm_cycle(1000, 300);
        if (evq.size() > 0) chk("post_rst.latency", evq[0].c - r1, 34);
        for (int i = 0; i < 2; i++) expect_ev("post_rst", 1000, 300, 30, 0);
        expect_none("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pwm_capture_module.md
Name: pwm_capture_module

Overview:
- Measures an incoming PWM waveform and reports its period (clock cycles), high time (cycles) and duty ratio (integer percent, 0–100).
- It is the receive side of the PWM path. It reads back what the duty/period adjust logic and the PWM generator produce, for loopback self-check and for capturing external PWM sources.
- Clocked at 50 MHz system clock. A period count of 250_000 corresponds to 5 ms.

Parameters:
- CNT_W, 24: width of the period and high-time counters.
- MAX_COUNT, 1_000_000: timeout threshold in cycles with no rising edge. Must be at least 2 and less than 2^CNT_W.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous reset, active-high.
- PWM_In  in  1  PWM input, asynchronous to CLK.
- Period_Cnt  out  CNT_W  last measured period in cycles, rising edge to rising edge.
- High_Cnt  out  CNT_W  last measured high time in cycles, rising edge to falling edge.
- Duty  out  8  floor(High_Cnt*100/Period_Cnt), clamped to 100.
- Valid  out  1  one-cycle pulse when the outputs are updated.
- Timeout  out  1  high while the input is stuck (no rising edge for MAX_COUNT cycles).

Behaviour:
- Reset (RST=1, asynchronous):
  - Period_Cnt=0, High_Cnt=0, Duty=0, Valid=0, Timeout=0.
  - Synchronizer flops = 0, counter = 0, state = IDLE.
- Input conditioning:
  - 2-flop synchronizer s1→s2, then s3 = s2 delayed one cycle.
  - rise = s2&~s3, fall = ~s2&s3.
  - An edge on PWM_In is detected 2–3 CLK cycles later. The fixed offset cancels out in all measurements.
- Cycle counter cnt:
  - On rise: cnt<=1.
  - Otherwise: cnt<=cnt+1, saturating at MAX_COUNT.
  - At a rise, cnt equals the cycles since the previous rise. At a fall, cnt equals the cycles since the last rise.
- Capture FSM states: IDLE, HIGH, LOW, DIVIDE.
  - IDLE: wait for rise → HIGH. Nothing is reported; the first rise after reset or timeout only arms the FSM.
  - HIGH: on fall, latch h_snap=cnt → LOW.
  - LOW: on rise, latch p_snap=cnt, start the divider → DIVIDE.
  - DIVIDE: sequential restoring divide of h_snap*100 (CNT_W+7 bits) by p_snap. Fixed CNT_W+7 iterations, one per cycle.
  - After the last iteration, in the next cycle:
    - Period_Cnt<=p_snap, High_Cnt<=h_snap.
    - Duty<=min(quotient,100).
    - Valid=1 for that cycle only; Timeout<=0.
    - Next state is HIGH, because the rise that ended this period has already started the next one.
  - Latency: Valid follows the rise-detect cycle by CNT_W+8 cycles (32 at default).
- Edges during DIVIDE:
  - cnt keeps running, so the next measurement's timebase is unaffected.
  - A fall during DIVIDE is latched into h_snap_next and used for the next period.
  - A second rise during DIVIDE (period < CNT_W+8 cycles) is unsupported. That period is discarded, and the FSM re-arms on the following rise.
- Timeout:
  - Trigger: cnt reaches MAX_COUNT in HIGH, LOW or IDLE. IDLE counts only after at least one edge since reset.
  - On trigger: Timeout<=1, Period_Cnt<=0, High_Cnt<=0, Duty<=100 if s2=1 else 0, one Valid pulse, state→IDLE.
  - Timeout stays 1 until the next completed measurement. No repeated Valid pulses while stuck.
- Duty is purely arithmetic: h_snap < p_snap always, so a 0% or 100% input can only be reported through timeout.
- Mid-operation reset: aborts any state, including DIVIDE. All outputs return to reset values immediately. No Valid pulse follows.
- Outputs hold their values between Valid pulses.

Test Plan:
- Reset → first Valid:
  - Stimulus: release RST, then drive PWM with period 1000 cycles and 300 high.
  - Required: the first Valid appears 32 cycles after the second detected rise. Period_Cnt=1000, High_Cnt=300, Duty=30, Timeout=0.
  - Required: a Valid follows every subsequent rise with identical values.
- Generator loopback:
  - Stimulus: Count_P=250_000, Duty=50.
  - Required: Period_Cnt=250_000, High_Cnt=125_000, Duty=50.
  - Required, after switching to Count_P=50_000, Duty=10: the first full new period reports 50_000/5_000/10.
- Truncation:
  - Stimulus: period 3 cycles*1000+7=3007, high 1002.
  - Required: Duty=33 (floor of 33.32).
- Stuck high:
  - Setup: MAX_COUNT=5000. After valid measurements, hold PWM_In=1.
  - Required: single Valid pulse with Timeout=1, Duty=100, Period_Cnt=0, High_Cnt=0.
  - Required, after toggling resumes: the second rise gives a normal Valid with Timeout=0.
- Stuck low:
  - Stimulus: same as stuck high, with PWM_In held at 0.
  - Required: Duty=0, Timeout=1.
- Reset mid-DIVIDE:
  - Stimulus: assert RST 10 cycles after a rise-detect.
  - Required: all outputs 0 the same cycle, no Valid afterwards.
  - Required, on resumed PWM: the first report comes after two rises.
